// File: rtl/sparse_chunk_writer.sv
// ============================================================================
// Module   : sparse_chunk_writer
// Purpose  : Compresses dense byte beats into a sparsemap plus packed nonzero
//            bytes and writes them into a double-buffered chunk store. Tracks
//            the occupancy of both banks so that a bank is never overwritten
//            before the compute side releases it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sparse_chunk_writer #(
  parameter int BUS_SIZE       = 32,
  parameter int WR_DAT_CYC_NUM = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [BUS_SIZE*8-1:0]             in_data_i,
  output logic [BUS_SIZE-1:0]               sparsemap_o,
  output logic [BUS_SIZE*8-1:0]             nonzero_data_o,
  output logic [$clog2(BUS_SIZE):0]         nz_count_o,
  output logic                              chunk_wr_valid_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0] chunk_wr_count_o,
  output logic                              chunk_wr_sel_o,
  output logic                              chunk_rd_sel_o,
  output logic                              chunk_ready_o,
  input  logic                              chunk_release_i,
  output logic                              release_err_o
);

  localparam int NZW  = $clog2(BUS_SIZE) + 1;
  localparam int CNTW = $clog2(WR_DAT_CYC_NUM);
  localparam logic [CNTW-1:0] C_CNT_MAX = CNTW'(WR_DAT_CYC_NUM - 1);

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                r_state;
  logic [CNTW-1:0]       r_cnt;       // index of the next beat to be written
  logic                  r_sel;       // bank the next beat goes to
  logic                  r_rd_sel;
  logic [1:0]            r_full;
  logic                  r_err;
  logic [BUS_SIZE-1:0]   r_map;
  logic [BUS_SIZE*8-1:0] r_data;
  logic [NZW-1:0]        r_nz;
  logic                  r_wvalid;
  logic [CNTW-1:0]       r_wcnt;
  logic                  r_wsel;

  logic [BUS_SIZE-1:0]   w_map;
  logic [BUS_SIZE*8-1:0] w_packed;
  logic [NZW-1:0]        w_nz;
  logic                  w_accept;
  logic                  w_rel_ok;
  logic                  w_set_last;
  logic [1:0]            w_full_nxt;

  // Held low during reset so every output reads zero while rst_i is asserted.
  assign in_ready_o = (r_state == S_FILL) & rst_i;
  assign w_accept   = in_valid_i & in_ready_o;
  assign w_rel_ok   = chunk_release_i & r_full[r_rd_sel];
  // The last beat of a bank is on the write port this cycle; the bank becomes full next cycle.
  assign w_set_last = r_wvalid & (r_wcnt == C_CNT_MAX);

  // Compaction: nonzero bytes are packed from byte 0 upward in ascending order.
  always_comb begin
    w_map    = '0;
    w_packed = '0;
    w_nz     = '0;
    for (int i = 0; i < BUS_SIZE; i++) begin
      if (in_data_i[8*i +: 8] != 8'h00) begin
        w_map[i]                      = 1'b1;
        w_packed[{w_nz, 3'b000} +: 8] = in_data_i[8*i +: 8];
        w_nz                          = w_nz + {{(NZW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Bank occupancy: a set and a release of different banks may coincide.
  always_comb begin
    w_full_nxt = r_full;
    if (w_set_last) w_full_nxt[r_wsel] = 1'b1;
    if (w_rel_ok)   w_full_nxt[r_rd_sel] = 1'b0;
  end

  // Write FSM, registered write-port outputs and bank bookkeeping.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_FILL;
      r_cnt    <= '0;
      r_sel    <= 1'b0;
      r_rd_sel <= 1'b0;
      r_full   <= 2'b00;
      r_err    <= 1'b0;
      r_map    <= '0;
      r_data   <= '0;
      r_nz     <= '0;
      r_wvalid <= 1'b0;
      r_wcnt   <= '0;
      r_wsel   <= 1'b0;
    end else begin
      r_wvalid <= w_accept;
      r_full   <= w_full_nxt;
      if (w_rel_ok) r_rd_sel <= ~r_rd_sel;
      if (chunk_release_i && !r_full[r_rd_sel]) r_err <= 1'b1;

      case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_map  <= w_map;
            r_data <= w_packed;
            r_nz   <= w_nz;
            r_wcnt <= r_cnt;
            r_wsel <= r_sel;
            r_cnt  <= r_cnt + 1'b1;
            if (r_cnt == C_CNT_MAX) begin
              r_sel <= ~r_sel;
              // Stall if the bank we are about to enter still holds unread data.
              if (r_full[~r_sel]) r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Resume as soon as the target bank is released, so input reopens next cycle.
          if (!w_full_nxt[r_sel]) r_state <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign sparsemap_o      = r_map;
  assign nonzero_data_o   = r_data;
  assign nz_count_o       = r_nz;
  assign chunk_wr_valid_o = r_wvalid;
  assign chunk_wr_count_o = r_wcnt;
  assign chunk_wr_sel_o   = r_wsel;
  assign chunk_rd_sel_o   = r_rd_sel;
  assign chunk_ready_o    = r_full[r_rd_sel];
  assign release_err_o    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sparse_chunk_writer.sv
// ============================================================================
// Module   : tb_sparse_chunk_writer
// Purpose  : Self-checking bench for sparse_chunk_writer (BUS_SIZE=8,
//            WR_DAT_CYC_NUM=4). Table-driven beats with a scoreboard queue,
//            plus directed sequences for stall, release and reset cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sparse_chunk_writer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_data_i = '0;
  logic [7:0]  sparsemap_o;
  logic [63:0] nonzero_data_o;
  logic [3:0]  nz_count_o;
  logic        chunk_wr_valid_o;
  logic [1:0]  chunk_wr_count_o;
  logic        chunk_wr_sel_o;
  logic        chunk_rd_sel_o;
  logic        chunk_ready_o;
  logic        chunk_release_i = 1'b0;
  logic        release_err_o;

  sparse_chunk_writer #(.BUS_SIZE(8), .WR_DAT_CYC_NUM(4)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .in_valid_i       (in_valid_i),
    .in_ready_o       (in_ready_o),
    .in_data_i        (in_data_i),
    .sparsemap_o      (sparsemap_o),
    .nonzero_data_o   (nonzero_data_o),
    .nz_count_o       (nz_count_o),
    .chunk_wr_valid_o (chunk_wr_valid_o),
    .chunk_wr_count_o (chunk_wr_count_o),
    .chunk_wr_sel_o   (chunk_wr_sel_o),
    .chunk_rd_sel_o   (chunk_rd_sel_o),
    .chunk_ready_o    (chunk_ready_o),
    .chunk_release_i  (chunk_release_i),
    .release_err_o    (release_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  map;
    logic [63:0] nzd;
    logic [3:0]  nz;
  } vec_t;

  typedef struct {
    logic [7:0]  map;
    logic [63:0] nzd;
    logic [3:0]  nz;
    logic [1:0]  cnt;
    logic        sel;
  } exp_t;

  vec_t vecs [0:7];
  vec_t v9;
  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   beat_idx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one beat (called right after a negedge); waits bounded for in_ready_o.
  task automatic send(input vec_t v);
    int n;
    exp_t e;
    in_valid_i = 1'b1;
    in_data_i  = v.d;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: actual=not_ready required=ready");
      return;
    end
    e.map = v.map; e.nzd = v.nzd; e.nz = v.nz;
    e.cnt = 2'(beat_idx % 4);
    e.sel = 1'((beat_idx / 4) % 2);
    sb.push_back(e);
    beat_idx++;
    @(negedge clk_i);
  endtask

  // Scoreboard: every write strobe must match the oldest outstanding beat.
  always @(negedge clk_i) begin
    if (rst_i && chunk_wr_valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sparsemap", {56'd0, sparsemap_o}, {56'd0, e.map});
        chk("nonzero_data", nonzero_data_o, e.nzd);
        chk("nz_count", {60'd0, nz_count_o}, {60'd0, e.nz});
        chk("wr_count", {62'd0, chunk_wr_count_o}, {62'd0, e.cnt});
        chk("wr_sel", {63'd0, chunk_wr_sel_o}, {63'd0, e.sel});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready_o}, 64'd0);
    chk({tag, "_sparsemap"}, {56'd0, sparsemap_o}, 64'd0);
    chk({tag, "_nzdata"}, nonzero_data_o, 64'd0);
    chk({tag, "_nzcount"}, {60'd0, nz_count_o}, 64'd0);
    chk({tag, "_wr_valid"}, {63'd0, chunk_wr_valid_o}, 64'd0);
    chk({tag, "_wr_count"}, {62'd0, chunk_wr_count_o}, 64'd0);
    chk({tag, "_wr_sel"}, {63'd0, chunk_wr_sel_o}, 64'd0);
    chk({tag, "_rd_sel"}, {63'd0, chunk_rd_sel_o}, 64'd0);
    chk({tag, "_chunk_ready"}, {63'd0, chunk_ready_o}, 64'd0);
    chk({tag, "_release_err"}, {63'd0, release_err_o}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h0900_0007_0000_0500, 8'h92, 64'h0000_0000_0009_0705, 4'd3};
    vecs[1] = '{64'h0000_0000_0000_0000, 8'h00, 64'h0000_0000_0000_0000, 4'd0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8};
    vecs[3] = '{64'h0000_0000_0000_0001, 8'h01, 64'h0000_0000_0000_0001, 4'd1};
    vecs[4] = '{64'h8000_0000_0000_0000, 8'h80, 64'h0000_0000_0000_0080, 4'd1};
    vecs[5] = '{64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708, 4'd8};
    vecs[6] = '{64'h00FF_00FF_00FF_00FF, 8'h55, 64'h0000_0000_FFFF_FFFF, 4'd4};
    vecs[7] = '{64'h1100_2200_0000_0033, 8'hA1, 64'h0000_0000_0011_2233, 4'd3};
    v9      = '{64'h0000_00AB_0000_0000, 8'h10, 64'h0000_0000_0000_00AB, 4'd1};

    // Reset state
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", {63'd0, in_ready_o}, 64'd1);

    // Eight back-to-back beats fill both banks
    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      if (i == 3) chk("chunk_ready_on_last_strobe", {63'd0, chunk_ready_o}, 64'd0);
      if (i == 4) chk("chunk_ready_after_last", {63'd0, chunk_ready_o}, 64'd1);
      if (i == 7) chk("in_ready_both_full", {63'd0, in_ready_o}, 64'd0);
    end

    // Ninth beat stalls with in_valid held
    in_valid_i = 1'b1;
    in_data_i  = v9.d;
    for (int k = 0; k < 3; k++) begin
      chk("stall_in_ready", {63'd0, in_ready_o}, 64'd0);
      @(negedge clk_i);
    end

    // Release bank 0: writer resumes next cycle, bank 1 still readable
    chunk_release_i = 1'b1;
    @(negedge clk_i);
    chunk_release_i = 1'b0;
    chk("rd_sel_after_release", {63'd0, chunk_rd_sel_o}, 64'd1);
    chk("in_ready_after_release", {63'd0, in_ready_o}, 64'd1);
    chk("chunk_ready_bank1", {63'd0, chunk_ready_o}, 64'd1);
    send(v9);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("wr_valid_idle", {63'd0, chunk_wr_valid_o}, 64'd0);
    chk("sparsemap_hold", {56'd0, sparsemap_o}, {56'd0, v9.map});
    chk("nzdata_hold", nonzero_data_o, v9.nzd);

    // Release bank 1, then an illegal release with nothing full
    chunk_release_i = 1'b1;
    @(negedge clk_i);
    chunk_release_i = 1'b0;
    chk("rd_sel_back_to_0", {63'd0, chunk_rd_sel_o}, 64'd0);
    chk("chunk_ready_none", {63'd0, chunk_ready_o}, 64'd0);
    chk("err_before_bad_release", {63'd0, release_err_o}, 64'd0);
    chunk_release_i = 1'b1;
    @(negedge clk_i);
    chunk_release_i = 1'b0;
    chk("release_err_set", {63'd0, release_err_o}, 64'd1);
    chk("rd_sel_unchanged", {63'd0, chunk_rd_sel_o}, 64'd0);
    repeat (3) @(negedge clk_i);
    chk("release_err_sticky", {63'd0, release_err_o}, 64'd1);

    // Reset in the middle of a chunk
    send(vecs[0]);
    send(vecs[6]);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    beat_idx = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    send(vecs[7]);
    in_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
